// File: rtl/alu_mdu_control.sv
// ALU control decoder with an iterative unsigned multiply/divide unit (HI/LO),
// busy/stall handshake toward the pipeline controller and mfhi/mflo readout.
module alu_mdu_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       alu_control,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [2:0] ALUOP_R = 3'b110;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;

  logic rtype, is_multu, is_divu, is_mfhi, mf_op, md_op;

  always_comb begin
    rtype       = (aluop == ALUOP_R);
    alu_control = aluop;
    if (rtype) begin
      case (funct)
        F_ADD:   alu_control = 3'b000;
        F_SUB:   alu_control = 3'b001;
        F_AND:   alu_control = 3'b010;
        F_OR:    alu_control = 3'b011;
        F_XOR:   alu_control = 3'b100;
        F_NOR:   alu_control = 3'b101;
        F_SLT:   alu_control = 3'b110;
        default: alu_control = 3'b111;
      endcase
    end
    is_multu = rtype && (funct == F_MULTU);
    is_divu  = rtype && (funct == F_DIVU);
    is_mfhi  = rtype && (funct == F_MFHI);
    mf_op    = is_mfhi || (rtype && (funct == F_MFLO));
    md_op    = is_multu || is_divu;
  end

  // valid/ready: start is the request; stall is a not-ready that holds EX while
  // an md op or HI/LO read meets a busy unit. busy drops in the done cycle.
  assign busy      = (state != IDLE);
  assign stall     = busy && start && (md_op || mf_op);
  assign md_sel    = start && mf_op && !stall;
  assign md_result = !md_sel ? '0 : (is_mfhi ? hi : lo);

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend shifting into quotient}.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = !div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_multu) begin
            acc   <= {{WIDTH{1'b0}}, b};
            opnd  <= a;
            cnt   <= '0;
            state <= MUL;
          end else if (start && is_divu) begin
            if (b == '0) begin
              hi   <= a;
              lo   <= '1;
              done <= 1'b1;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a};
              opnd  <= b;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            hi    <= mul_next[2*WIDTH-1:WIDTH];
            lo    <= mul_next[WIDTH-1:0];
            cnt   <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            hi    <= div_next[2*WIDTH-1:WIDTH];
            lo    <= div_next[WIDTH-1:0];
            cnt   <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_control.sv
// Bench for alu_mdu_control: directed test-plan steps plus randomized multu/divu
// traffic checked against an arithmetic reference model and an expected queue.
module tb_alu_mdu_control;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   aluop = 3'b000;
  logic [5:0]   funct = 6'b000000;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   alu_control;
  logic         md_sel, busy, stall, done;
  logic [W-1:0] md_result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_hi, model_lo;

  alu_mdu_control #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .alu_control(alu_control), .md_sel(md_sel),
    .md_result(md_result), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the opcode table.
  function automatic logic [2:0] ref_dec(input logic [2:0] op, input logic [5:0] f);
    if (op != 3'b110) return op;
    case (f)
      6'b100000: return 3'd0;
      6'b100010: return 3'd1;
      6'b100100: return 3'd2;
      6'b100101: return 3'd3;
      6'b100110: return 3'd4;
      6'b100111: return 3'd5;
      6'b101010: return 3'd6;
      default:   return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    if (f == F_MULTU) begin
      p = 64'(x) * 64'(y);
      return p;
    end
    if (y == 0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  // Present an md op for one edge (E0), then drop start; queue its result.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; aluop = 3'b110; funct = f; a = x; b = y;
    exp_q.push_back(ref_md(f, x, y));
    step();
    start = 1'b0;
  endtask

  // Count busy cycles (bounded), checking that HI/LO hold their old values.
  task automatic wait_busy(input string tag, output int n);
    n = 0;
    while (busy && n < 100) begin
      if (n == 5) begin
        check({tag, "_hold_hi"}, hi, model_hi);
        check({tag, "_hold_lo"}, lo, model_lo);
      end
      n++;
      step();
    end
  endtask

  task automatic finish_op(input string tag);
    logic [63:0] e;
    check({tag, "_done"}, done, 1'b1);
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  initial begin
    int n, ndone;
    logic [2:0] op;
    logic [5:0] f;
    logic [5:0] alu_f[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010};
    model_hi = '0;
    model_lo = '0;

    step();
    step();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Decode sweep (start low so nothing issues).
    aluop = 3'b010; #1 check("dec_010", alu_control, 3'b010);
    aluop = 3'b110; funct = 6'b100010; #1 check("dec_sub", alu_control, 3'b001);
    funct = 6'b101010; #1 check("dec_slt", alu_control, 3'b110);
    funct = F_MULTU; #1 check("dec_multu", alu_control, 3'b111);
    funct = 6'b000000; #1 check("dec_zero", alu_control, 3'b111);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      f = (i % 2 == 0) ? alu_f[$urandom_range(0, 6)] : 6'($urandom);
      aluop = op; funct = f;
      #1 check("dec_rand", alu_control, ref_dec(op, f));
    end
    step();

    // multu 0xFFFFFFFF * 2
    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_busy("mul1", n);
    check("mul1_busy_len", n, 32);
    finish_op("mul1");
    step();
    check("mul1_done_pulse", done, 0);

    // divu 100 / 7, then mflo
    issue(F_DIVU, 32'd100, 32'd7);
    wait_busy("div1", n);
    check("div1_busy_len", n, 32);
    finish_op("div1");
    start = 1'b1; aluop = 3'b110; funct = F_MFLO;
    #1 check("mflo_sel", md_sel, 1);
    check("mflo_val", md_result, 14);
    step();
    start = 1'b0;

    // mfhi presented during busy: stalled until the done cycle
    issue(F_DIVU, 32'd100, 32'd7);
    start = 1'b1; aluop = 3'b110; funct = F_MFHI;
    n = 0;
    #1;
    while (busy && n < 100) begin
      if (stall !== 1'b1) check("mfhi_stall", stall, 1);
      n++;
      step();
    end
    check("mfhi_stall_len", n, 32);
    check("mfhi_done_stall", stall, 0);
    check("mfhi_sel", md_sel, 1);
    check("mfhi_val", md_result, 2);
    finish_op("div2");
    step();
    start = 1'b0;

    // divu by zero
    issue(F_DIVU, 32'h1234_5678, 32'd0);
    check("div0_busy", busy, 0);
    finish_op("div0");
    step();
    check("div0_done_pulse", done, 0);

    // multu 3*5, divu 9/3 held from cycle 10 while busy
    issue(F_MULTU, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) step();
    start = 1'b1; aluop = 3'b110; funct = F_DIVU; a = 32'd9; b = 32'd3;
    #1 check("ovl_stall", stall, 1);
    check("ovl_busy", busy, 1);
    n = 9;
    while (busy && n < 100) begin n++; step(); end
    check("ovl_busy_len", n, 32);
    check("ovl_done_stall", stall, 0);
    finish_op("ovl_mul");
    exp_q.push_back(ref_md(F_DIVU, 32'd9, 32'd3));
    step();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1;
    check("ovl_div_busy", busy, 1);
    wait_busy("ovl_div", n);
    check("ovl_div_len", n, 32);
    finish_op("ovl_div");

    // reset mid multiply
    issue(F_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    for (int i = 0; i < 15; i++) step();
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_hi", hi, 0);
    check("mrst_lo", lo, 0);
    void'(exp_q.pop_front());
    model_hi = '0; model_lo = '0;
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) ndone++;
    end
    check("mrst_no_done", ndone, 0);

    // Randomized md traffic with ALU ops and operand churn while busy.
    for (int k = 0; k < 20; k++) begin
      logic [5:0] mf;
      logic [W-1:0] ra, rb;
      mf = ($urandom_range(0, 1) == 0) ? F_MULTU : F_DIVU;
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 300)) : $urandom;
      if (mf == F_DIVU && $urandom_range(0, 4) == 0) rb = '0;
      issue(mf, ra, rb);
      if (mf == F_DIVU && rb == 0) begin
        check("rnd_div0_busy", busy, 0);
      end else begin
        n = 0;
        while (busy && n < 100) begin
          a = $urandom; b = $urandom;
          start = 1'b1; aluop = 3'b110; funct = alu_f[$urandom_range(0, 6)];
          #1;
          if (stall !== 1'b0) check("rnd_alu_stall", stall, 0);
          if (alu_control !== ref_dec(aluop, funct)) check("rnd_alu_dec", alu_control, ref_dec(aluop, funct));
          if (n == 7) begin
            check("rnd_hold_hi", hi, model_hi);
            check("rnd_hold_lo", lo, model_lo);
          end
          n++;
          step();
        end
        start = 1'b0;
        check("rnd_busy_len", n, 32);
      end
      finish_op("rnd");
      step();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
- Parametrised next-generation ALU control for the multi-cycle MIPS core.
- Decodes aluop/funct into the 3-bit ALU operation, as the existing decoder does, and covers more funct codes.
- Adds an iterative unsigned multiply/divide unit with HI/LO registers, a busy/stall handshake to the pipeline controller, and mfhi/mflo readout.
- Sits between the main controller (aluop), the instruction register (funct), the register file (a, b) and the writeback mux.

Parameters:
- WIDTH, 32, operand, HI and LO width (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  instruction valid in EX; sampled on the rising edge.
- aluop  in  3  from main controller; 3'b110 = R-type, decode funct.
- funct  in  6  instruction[5:0].
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- alu_control  out  3  ALU operation select (combinational).
- md_sel  out  1  current op is mfhi/mflo; writeback takes md_result.
- md_result  out  WIDTH  HI for mfhi, LO for mflo, else 0.
- busy  out  1  multiply/divide iteration in progress.
- stall  out  1  pipeline must hold EX.
- done  out  1  one-cycle pulse when HI/LO have just been updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Decode (combinational):
  - If aluop != 3'b110, alu_control = aluop.
  - If aluop == 3'b110, funct maps as: 100000 add->000, 100010 sub->001, 100100 and->010, 100101 or->011, 100110 xor->100, 100111 nor->101, 101010 slt->110.
  - Any other funct -> 111 (invalid/nop), including 011001 multu, 011011 divu, 010000 mfhi, 010010 mflo.
- md ops are only those four funct codes, and only with aluop == 3'b110.
- FSM states: IDLE, MUL, DIV. Reset -> IDLE.
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, counter = 0. All internal accumulators cleared.
- Issue: start=1 with multu or divu in IDLE, sampled on edge E0.
  - multu: latch a, b; go to MUL; counter = 0.
  - divu with b != 0: same, go to DIV.
  - divu with b == 0: stay IDLE; at E0 write hi = a, lo = {WIDTH{1'b1}}; done = 1 for the following cycle; busy never asserts.
- MUL (shift-add):
  - One multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
  - After WIDTH iteration edges (edge E0+WIDTH), write {hi,lo} = a*b, return to IDLE, done = 1 for one cycle.
- DIV (restoring):
  - One quotient bit per cycle, MSB first.
  - At E0+WIDTH, write lo = quotient and hi = remainder, return to IDLE, done = 1 for one cycle.
- busy = 1 in MUL/DIV, i.e. for exactly WIDTH cycles after E0.
- hi/lo change only at the completion edge. They hold their old values while busy.
- stall = busy & start & (md op or mfhi/mflo).
  - Stall is deasserted combinationally in the done cycle, so a dependent mfhi issued then reads the new value.
- start with an md op while busy: ignored, stalled. The unit does not restart or abort.
- ALU ops (non-md) issued while busy: not stalled; decode proceeds normally.
- mfhi/mflo: md_sel = 1 when start and the decoded op is mfhi/mflo and not stalled; md_result is combinational from hi/lo.
- Simultaneous done and a new multu/divu start in IDLE: accepted normally; done pulses, and busy rises next cycle.
- Reset asserted mid-operation: immediately returns to IDLE with all outputs at reset values. The partial result is discarded.
- Widths: all arithmetic is unsigned. The product is exactly 2*WIDTH bits with no overflow. a and b are captured at issue, so later changes have no effect.

Test Plan (WIDTH=32):
- Decode sweep:
  - aluop=010 -> alu_control=010.
  - aluop=110 with funct 100010 -> 001; 101010 -> 110; 011001 -> 111; 000000 -> 111.
- multu a=0xFFFFFFFF, b=2 -> busy high for exactly 32 cycles, then done pulse; hi=0x00000001, lo=0xFFFFFFFE.
- divu a=100, b=7 -> after 32 busy cycles, lo=14, hi=2.
  - Then mflo -> md_sel=1, md_result=14.
  - mfhi issued during busy -> stall=1 until the done cycle, then md_result=2.
- divu a=0x12345678, b=0 -> busy stays 0, done next cycle; hi=0x12345678, lo=0xFFFFFFFF.
- Start multu 3*5, then at cycle 10 issue divu 9/3:
  - The divu is ignored and stall=1; hi:lo=0:15 after 32 cycles.
  - The divu reissued in the done cycle gives lo=3, hi=0.
- Start multu 0xFFFF*0xFFFF, assert rst at cycle 16 -> busy=0, hi=lo=0 immediately; no done pulse afterwards.
